// File: rtl/updown_counter_mod.sv
// Up/down counter with runtime modulus, programmable step and wrap/saturate boundaries.
// Optional compare output (CMP_VAL/MATCH) is built when COUNTER_CMP_EN is defined.
module updown_counter_mod #(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              E,
  input  logic              D,
  input  logic              LOAD,
  input  logic [N-1:0]      DATA_IN,
  input  logic [STEP_W-1:0] STEP,
  input  logic [N-1:0]      LIMIT,
  input  logic              SAT,
  output logic [N-1:0]      OUT,
  output logic              TC,
  output logic              WRAP
`ifdef COUNTER_CMP_EN
  ,
  input  logic [N-1:0]      CMP_VAL,
  output logic              MATCH
`endif
);

  localparam int W = N + 1;

  logic [N:0]   lim1;
  logic [N:0]   step_ext;
  logic [N:0]   s_eff;
  logic [N:0]   cur;
  logic [N:0]   up_sum;
  logic [N-1:0] next_out;
  logic         next_wrap;

  // All boundary arithmetic is done one bit wider so LIMIT+1 and OUT+s never overflow.
  always_comb begin
    lim1      = {1'b0, LIMIT} + W'(1);
    step_ext  = W'(STEP);
    s_eff     = (step_ext < lim1) ? step_ext : lim1;
    cur       = {1'b0, OUT};
    up_sum    = cur + s_eff;
    next_out  = OUT;
    next_wrap = 1'b0;
    if (LOAD) begin
      next_out = (DATA_IN > LIMIT) ? LIMIT : DATA_IN;
    end else if (E && (s_eff != '0)) begin
      next_wrap = 1'b1;
      if (OUT > LIMIT) begin
        next_out = LIMIT;
      end else if (!D) begin
        if (up_sum <= {1'b0, LIMIT}) begin
          next_out  = N'(up_sum);
          next_wrap = 1'b0;
        end else if (SAT) begin
          next_out = LIMIT;
        end else begin
          next_out = N'(up_sum - lim1);
        end
      end else begin
        if (cur >= s_eff) begin
          next_out  = N'(cur - s_eff);
          next_wrap = 1'b0;
        end else if (SAT) begin
          next_out = '0;
        end else begin
          next_out = N'(cur + (lim1 - s_eff));
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT  <= '0;
      WRAP <= 1'b0;
    end else begin
      OUT  <= next_out;
      WRAP <= next_wrap;
    end
  end

`ifdef COUNTER_CMP_EN
  // Compare against the next value so MATCH lines up with the OUT it describes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MATCH <= 1'b0;
    end else begin
      MATCH <= (next_out == CMP_VAL);
    end
  end
`endif

  always_comb begin
    TC = ((!D) && (OUT == LIMIT)) || (D && (OUT == '0));
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod (N=8, STEP_W=4): directed scenarios plus
// randomized traffic against a modular-arithmetic reference model.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       e = 1'b0;
  logic       d = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data_in = '0;
  logic [3:0] step = '0;
  logic [7:0] limit = '0;
  logic       sat = 1'b0;
  logic [7:0] out;
  logic       tc;
  logic       wrap;
`ifdef COUNTER_CMP_EN
  logic [7:0] cmp_val = '0;
  logic       match;
`endif

  int total = 0;
  int bad = 0;

  int m_out = 0;
  int m_wrap = 0;
  int m_match = 0;

  updown_counter_mod #(.N(8), .STEP_W(4)) dut (
    .CLK(clk), .RST(rst), .E(e), .D(d), .LOAD(load), .DATA_IN(data_in),
    .STEP(step), .LIMIT(limit), .SAT(sat), .OUT(out), .TC(tc), .WRAP(wrap)
`ifdef COUNTER_CMP_EN
    , .CMP_VAL(cmp_val), .MATCH(match)
`endif
  );

  always #5 clk = ~clk;

  // Reference: count range is the ring 0..limit; wrap is modulo limit+1.
  task automatic predict();
    int lim1;
    int s;
    lim1 = int'(limit) + 1;
    s = (int'(step) < lim1) ? int'(step) : lim1;
    if (load) begin
      m_out = (int'(data_in) < int'(limit)) ? int'(data_in) : int'(limit);
      m_wrap = 0;
    end else if (!e || s == 0) begin
      m_wrap = 0;
    end else if (m_out > int'(limit)) begin
      m_out = int'(limit);
      m_wrap = 1;
    end else if (!d) begin
      if (m_out + s <= int'(limit)) begin
        m_out = m_out + s; m_wrap = 0;
      end else begin
        m_out = sat ? int'(limit) : (m_out + s) % lim1;
        m_wrap = 1;
      end
    end else begin
      if (m_out >= s) begin
        m_out = m_out - s; m_wrap = 0;
      end else begin
        m_out = sat ? 0 : (m_out - s + lim1) % lim1;
        m_wrap = 1;
      end
    end
`ifdef COUNTER_CMP_EN
    m_match = (m_out == int'(cmp_val)) ? 1 : 0;
`endif
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    m_out = 0; m_wrap = 0; m_match = 0;
    @(posedge clk);
    #1;
    load = 1'b0; e = 1'b0;
  endtask

  task automatic test_reset();
    limit = 8'd9; d = 1'b0; e = 1'b0; load = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (out !== 8'd0 || wrap !== 1'b0 || tc !== 1'b0) begin
      bad++; $display("FAIL reset_state out=%0h wrap=%0b tc=%0b want 0/0/0", out, wrap, tc);
    end
    rst = 1'b0;
    m_out = 0; m_wrap = 0; m_match = 0;
    @(posedge clk); #1;
    // Count up to 0x37, then async reset between edges.
    limit = 8'hFF; step = 4'd1; sat = 1'b0; e = 1'b1;
    for (int i = 0; i < 55; i++) tick();
    total++;
    if (out !== 8'h37) begin
      bad++; $display("FAIL count_to_37 out=%0h want 37", out);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (out !== 8'h00 || wrap !== 1'b0) begin
      bad++; $display("FAIL async_reset out=%0h wrap=%0b want 00/0", out, wrap);
    end
    #1 rst = 1'b0;
    m_out = 0; m_wrap = 0; m_match = 0;
    tick();
    total++;
    if (out !== 8'h01) begin
      bad++; $display("FAIL after_release1 out=%0h want 01", out);
    end
    tick();
    total++;
    if (out !== 8'h02) begin
      bad++; $display("FAIL after_release2 out=%0h want 02", out);
    end
    e = 1'b0;
  endtask

  task automatic test_wrap_up();
    do_reset();
    limit = 8'd9; step = 4'd1; d = 1'b0; sat = 1'b0; e = 1'b1;
    #1;
    total++;
    if (out !== 8'd0 || tc !== 1'b0) begin
      bad++; $display("FAIL wrap_up_start out=%0d tc=%0b want 0/0", out, tc);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++;
      if (out !== 8'(k % 10) || wrap !== (k == 10) || tc !== ((k % 10) == 9)) begin
        bad++;
        $display("FAIL wrap_up k=%0d out=%0d wrap=%0b tc=%0b want %0d/%0b/%0b",
                 k, out, wrap, tc, k % 10, (k == 10), ((k % 10) == 9));
      end
    end
    e = 1'b0;
  endtask

  task automatic test_wrap_down();
    logic [7:0] exp_o [3];
    logic       exp_w [3];
    exp_o = '{8'h02, 8'hFF, 8'hFC};
    exp_w = '{1'b0, 1'b1, 1'b0};
    load = 1'b1; data_in = 8'h05; limit = 8'hFF; e = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (out !== 8'h05 || wrap !== 1'b0) begin
      bad++; $display("FAIL load05 out=%0h wrap=%0b want 05/0", out, wrap);
    end
    step = 4'd3; d = 1'b1; sat = 1'b0; e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out !== exp_o[i] || wrap !== exp_w[i]) begin
        bad++; $display("FAIL wrap_down i=%0d out=%0h wrap=%0b want %0h/%0b",
                        i, out, wrap, exp_o[i], exp_w[i]);
      end
    end
    e = 1'b0;
  endtask

  task automatic test_saturate();
    limit = 8'd100; step = 4'd7; sat = 1'b1; d = 1'b0;
    load = 1'b1; data_in = 8'd95; e = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (out !== 8'd95) begin
      bad++; $display("FAIL sat_load out=%0d want 95", out);
    end
    e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out !== 8'd100 || wrap !== 1'b1 || tc !== 1'b1) begin
        bad++; $display("FAIL sat_hold i=%0d out=%0d wrap=%0b tc=%0b want 100/1/1",
                        i, out, wrap, tc);
      end
    end
    d = 1'b1;
    tick();
    total++;
    if (out !== 8'd93 || wrap !== 1'b0) begin
      bad++; $display("FAIL sat_down out=%0d wrap=%0b want 93/0", out, wrap);
    end
    e = 1'b0;
  endtask

  task automatic test_load_priority();
    load = 1'b1; e = 1'b1; data_in = 8'hC8; limit = 8'h64; d = 1'b0; step = 4'd1; sat = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (out !== 8'h64 || wrap !== 1'b0) begin
      bad++; $display("FAIL load_clamp out=%0h wrap=%0b want 64/0", out, wrap);
    end
    limit = 8'h20;
    tick();
    total++;
    if (out !== 8'h20 || wrap !== 1'b1) begin
      bad++; $display("FAIL limit_lowered out=%0h wrap=%0b want 20/1", out, wrap);
    end
    e = 1'b0;
    tick();
    total++;
    if (out !== 8'h20 || wrap !== 1'b0) begin
      bad++; $display("FAIL hold out=%0h wrap=%0b want 20/0", out, wrap);
    end
  endtask

  task automatic test_limit_zero();
    limit = 8'd0; step = 4'd5; e = 1'b1; d = 1'b0; sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = i[0]; sat = i[1];
      tick();
      total++;
      if (out !== 8'd0 || wrap !== 1'b1) begin
        bad++; $display("FAIL limit0 i=%0d out=%0d wrap=%0b want 0/1", i, out, wrap);
      end
    end
    step = 4'd0;
    tick();
    total++;
    if (out !== 8'd0 || wrap !== 1'b0) begin
      bad++; $display("FAIL step0 out=%0d wrap=%0b want 0/0", out, wrap);
    end
    e = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    limit = 8'd50;
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 7) != 0);
      d = $urandom_range(0, 1);
      sat = ($urandom_range(0, 3) == 0);
      step = 4'($urandom_range(0, 15));
      data_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) limit = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 29) == 0) limit = 8'($urandom_range(0, 3));
`ifdef COUNTER_CMP_EN
      cmp_val = 8'($urandom_range(0, 3) == 0 ? m_out : $urandom_range(0, 255));
`endif
      if (!load && e && step == 4'd0 && m_out > int'(limit)) step = 4'd1;
      tick();
      total++;
      if (int'(out) !== m_out || int'(wrap) !== m_wrap) begin
        bad++; $display("FAIL random i=%0d out=%0d wrap=%0b want %0d/%0d", i, out, wrap, m_out, m_wrap);
      end
      total++;
      if (tc !== (((!d) && m_out == int'(limit)) || (d && m_out == 0))) begin
        bad++; $display("FAIL random_tc i=%0d tc=%0b out=%0d limit=%0d d=%0b", i, tc, out, limit, d);
      end
`ifdef COUNTER_CMP_EN
      total++;
      if (int'(match) !== m_match) begin
        bad++; $display("FAIL random_match i=%0d match=%0b want %0d", i, match, m_match);
      end
`endif
    end
    load = 1'b0; e = 1'b0;
  endtask

`ifdef COUNTER_CMP_EN
  task automatic test_cmp();
    logic [7:0] exp_o [3];
    logic       exp_m [3];
    exp_o = '{8'h0F, 8'h10, 8'h11};
    exp_m = '{1'b0, 1'b1, 1'b0};
    cmp_val = 8'h10; limit = 8'hFF; step = 4'd1; d = 1'b0; sat = 1'b0;
    load = 1'b1; data_in = 8'h0E; e = 1'b0;
    tick();
    load = 1'b0; e = 1'b1;
    total++;
    if (match !== 1'b0) begin
      bad++; $display("FAIL cmp_load0e match=%0b want 0", match);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out !== exp_o[i] || match !== exp_m[i]) begin
        bad++; $display("FAIL cmp_count i=%0d out=%0h match=%0b want %0h/%0b",
                        i, out, match, exp_o[i], exp_m[i]);
      end
    end
    load = 1'b1; data_in = 8'h10;
    tick();
    load = 1'b0; e = 1'b0;
    total++;
    if (out !== 8'h10 || match !== 1'b1) begin
      bad++; $display("FAIL cmp_load10 out=%0h match=%0b want 10/1", out, match);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_priority();
    test_limit_zero();
`ifdef COUNTER_CMP_EN
    test_cmp();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
